// File: rtl/quant_pkg.sv
// Shared types for the quantizer scheduling stage: coefficient/block payloads and FSM states.
package quant_pkg;

    localparam int unsigned COEF_W  = 11;
    localparam int unsigned LUMA_CH = 0;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [0:7][0:7]         block_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } qs_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request after ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter int unsigned  NUM_CH = 3,
    localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_CH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quant_scheduler.sv
// Time-shares one 8x8 quantizer between NUM_CH DCT block producers and forwards
// each quantized block, tagged with its channel, over a valid/ready interface.
module quant_scheduler
    import quant_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    input  block_t                    blk_in [NUM_CH],
    output logic [NUM_CH-1:0]         grant,
    output logic                      q_enable,
    output block_t                    q_Z,
    output logic                      q_chroma,
    input  block_t                    q_Q,
    input  logic                      q_out_enable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output block_t                    out_blk,
    output logic [$clog2(NUM_CH)-1:0] out_chan,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          blk_count
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    qs_state_t         state;
    qs_state_t         state_n;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   sel;
    logic [NUM_CH-1:0] arb_gnt;
    logic [TMR_W-1:0]  timer;
    logic              any_req;
    logic              timer_done;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    assign any_req    = |req;
    assign timer_done = (timer == TMR_W'(TIMEOUT - 1));

    // One-hot grant to channel index
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                sel = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; grant, q_enable and out_valid are decodes of the current state
    always_comb begin
        state_n   = state;
        grant     = '0;
        q_enable  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                grant = arb_gnt;
                if (any_req) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                q_enable = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (q_out_enable) begin
                    state_n = HOLD;
                end else if (timer_done) begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Block latch, wait timer, result capture and bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= CH_W'(NUM_CH - 1);
            cur_ch      <= '0;
            q_Z         <= '0;
            q_chroma    <= 1'b0;
            timer       <= '0;
            out_blk     <= '0;
            out_chan    <= '0;
            timeout_err <= 1'b0;
            blk_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        q_Z      <= blk_in[sel];
                        q_chroma <= (sel != CH_W'(LUMA_CH));
                        cur_ch   <= sel;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (q_out_enable) begin
                        out_blk  <= q_Q;
                        out_chan <= cur_ch;
                    end else if (timer_done) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= cur_ch;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        blk_count <= blk_count + CNT_W'(1);
                        rr_ptr    <= cur_ch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quant_scheduler.sv
// Bench for quant_scheduler: directed scenarios plus randomized traffic against a
// timestamp-based transaction model of the scheduler.
module tb_quant_scheduler;
    import quant_pkg::*;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CH_W    = $clog2(NUM_CH);

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_CH-1:0]   req;
    block_t              blk_in [NUM_CH];
    logic [NUM_CH-1:0]   grant;
    logic                q_enable;
    block_t              q_Z;
    logic                q_chroma;
    block_t              q_Q = '0;
    logic                q_out_enable = 1'b0;
    logic                out_valid;
    logic                out_ready;
    block_t              out_blk;
    logic [CH_W-1:0]     out_chan;
    logic                timeout_err;
    logic [CNT_W-1:0]    blk_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    quant_scheduler #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .blk_in       (blk_in),
        .grant        (grant),
        .q_enable     (q_enable),
        .q_Z          (q_Z),
        .q_chroma     (q_chroma),
        .q_Q          (q_Q),
        .q_out_enable (q_out_enable),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_blk      (out_blk),
        .out_chan     (out_chan),
        .timeout_err  (timeout_err),
        .blk_count    (blk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string name, input block_t act, input block_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural quantizer: each coefficient halved, rounding toward minus infinity
    function automatic block_t quant(input block_t z);
        block_t r;
        coef_t  c;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                c       = z[i][j];
                r[i][j] = c >>> 1;
            end
        end
        return r;
    endfunction

    function automatic block_t rand_blk();
        block_t b;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                b[i][j] = coef_t'($urandom_range(0, 2047));
            end
        end
        return b;
    endfunction

    // First requester strictly after 'last', wrapping; -1 when nobody asks
    function automatic int pick(input logic [NUM_CH-1:0] r, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (last + k) % NUM_CH;
            if (r[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    // Quantizer stand-in: answers L cycles after q_enable, optionally never, optionally spuriously
    int q_lat  = 4;
    bit q_mute = 1'b0;
    bit rnd_q  = 1'b0;
    bit q_act  = 1'b0;
    int q_cnt  = 0;

    always @(posedge clk) begin
        int  lat;
        bit  mute;
        #1;
        q_out_enable = 1'b0;
        if (q_act) begin
            q_cnt--;
            if (q_cnt == 0) begin
                q_out_enable = 1'b1;
                q_Q          = quant(q_Z);
                q_act        = 1'b0;
            end
        end else if (rnd_q && $urandom_range(0, 39) == 0) begin
            q_out_enable = 1'b1;
            q_Q          = quant(q_Z);
        end
        if (q_enable === 1'b1) begin
            lat  = rnd_q ? int'($urandom_range(1, 6)) : q_lat;
            mute = rnd_q ? ($urandom_range(0, 7) == 0) : q_mute;
            if (!mute) begin
                q_act = 1'b1;
                q_cnt = lat;
            end
        end
    end

    // Transaction model: one block in flight, tracked by grant cycle and response cycle
    bit               m_busy   = 1'b0;
    int               m_ch     = 0;
    int               m_tg     = 0;
    int               m_resp   = -1;
    int               m_last   = NUM_CH - 1;
    bit               m_err    = 1'b0;
    bit               m_chroma = 1'b0;
    logic [CNT_W-1:0] m_cnt    = '0;
    block_t           m_z      = '0;
    block_t           m_out    = '0;
    int               m_outch  = 0;

    always @(negedge clk) begin
        int                p;
        logic [NUM_CH-1:0] eg;
        bit                eq;
        bit                ev;
        p  = pick(req, m_last);
        eg = '0;
        if (!m_busy && p >= 0) eg[p] = 1'b1;
        eq = m_busy && (cyc == m_tg + 1);
        ev = m_busy && (m_resp >= 0) && (cyc > m_resp);
        if (chk_en) begin
            chk("grant", 64'(grant), 64'(eg));
            chk("q_enable", 64'(q_enable), 64'(eq));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("q_chroma", 64'(q_chroma), 64'(m_chroma));
            chk("out_chan", 64'(out_chan), 64'(m_outch));
            chk("timeout_err", 64'(timeout_err), 64'(m_err));
            chk("blk_count", 64'(blk_count), 64'(m_cnt));
            chk_blk("q_z", q_Z, m_z);
            chk_blk("out_blk", out_blk, m_out);
            if (ev) chk_blk("out_blk_quant", out_blk, quant(m_z));
        end
        if (rst === 1'b1) begin
            m_busy   = 1'b0;
            m_last   = NUM_CH - 1;
            m_err    = 1'b0;
            m_cnt    = '0;
            m_z      = '0;
            m_out    = '0;
            m_outch  = 0;
            m_chroma = 1'b0;
        end else if (!m_busy) begin
            if (p >= 0) begin
                m_busy   = 1'b1;
                m_ch     = p;
                m_tg     = cyc;
                m_resp   = -1;
                m_z      = blk_in[p];
                m_chroma = (p != 0);
            end
        end else if (m_resp < 0) begin
            if (cyc >= m_tg + 2 && q_out_enable === 1'b1) begin
                m_resp  = cyc;
                m_out   = q_Q;
                m_outch = m_ch;
            end else if (cyc == m_tg + 1 + TIMEOUT) begin
                m_err  = 1'b1;
                m_last = m_ch;
                m_busy = 1'b0;
            end
        end else if (out_ready === 1'b1) begin
            m_cnt  = m_cnt + CNT_W'(1);
            m_last = m_ch;
            m_busy = 1'b0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (out_valid !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_valid", 64'(out_valid), 64'(1));
    endtask

    task automatic drain();
        wait_valid(40);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                n;
        int                ng;
        int                nc;
        bit                seen_v;
        logic [NUM_CH-1:0] gl [4];
        bit                cl [4];
        logic [NUM_CH-1:0] exp_g [4];
        bit                exp_c [4];
        logic [NUM_CH-1:0] last_g;
        block_t            b;

        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_c = '{1'b0, 1'b1, 1'b1, 1'b0};
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) blk_in[c] = '0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_blk_count", 64'(blk_count), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        chk_blk("rst_q_z", q_Z, '0);

        // Single luma block, quantizer latency 4
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                b[i][j] = coef_t'(100 + 8 * i + j);
        blk_in[0] = b;
        q_lat     = 4;
        req       = 3'b001;
        #1;
        chk("t1_grant", 64'(grant), 64'(3'b001));
        tick();
        req = '0;
        chk("t1_q_enable", 64'(q_enable), 64'(1));
        chk("t1_q_chroma", 64'(q_chroma), 64'(0));
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t1_latency", 64'(n), 64'(6));
        chk("t1_blk00", 64'($signed(out_blk[0][0])), 64'(50));
        chk("t1_blk77", 64'($signed(out_blk[7][7])), 64'(81));
        chk("t1_chan", 64'(out_chan), 64'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_count", 64'(blk_count), 64'(1));
        chk("t1_valid_low", 64'(out_valid), 64'(0));

        // All three channels requesting continuously
        reset_dut();
        q_lat     = 1;
        out_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) blk_in[c] = rand_blk();
        for (int k = 0; k < 4; k++) begin
            gl[k] = '0;
            cl[k] = 1'b0;
        end
        req = 3'b111;
        ng  = 0;
        nc  = 0;
        for (int k = 0; k < 80 && nc < 4; k++) begin
            #1;
            if (grant != '0 && ng < 4) begin
                gl[ng] = grant;
                ng++;
            end
            tick();
            if (ng >= 4) req = '0;
            if (q_enable === 1'b1 && nc < 4) begin
                cl[nc] = q_chroma;
                nc++;
            end
        end
        req = '0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_grant_order", 64'(gl[k]), 64'(exp_g[k]));
            chk("t2_chroma_seq", 64'(cl[k]), 64'(exp_c[k]));
        end
        n = 0;
        while (blk_count !== CNT_W'(4) && n < 40) begin
            tick();
            n++;
        end
        chk("t2_count", 64'(blk_count), 64'(4));
        out_ready = 1'b0;

        // Backpressure in HOLD while channel 1 waits
        reset_dut();
        q_lat     = 2;
        blk_in[0] = rand_blk();
        blk_in[1] = rand_blk();
        req       = 3'b001;
        tick();
        req = '0;
        wait_valid(20);
        req = 3'b010;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t3_no_grant", 64'(grant), 64'(0));
            chk("t3_hold_chan", 64'(out_chan), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t3_grant_after", 64'(grant), 64'(3'b010));
        tick();
        req = '0;
        drain();

        // Quantizer never answers
        reset_dut();
        q_mute = 1'b1;
        req    = 3'b001;
        tick();
        req = '0;
        chk("t4_q_enable", 64'(q_enable), 64'(1));
        n      = 0;
        seen_v = 1'b0;
        while (timeout_err !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (out_valid === 1'b1) seen_v = 1'b1;
        end
        chk("t4_timeout_delay", 64'(n), 64'(65));
        chk("t4_no_valid", 64'(seen_v), 64'(0));
        q_mute = 1'b0;
        req    = 3'b011;
        #1;
        chk("t4_next_grant", 64'(grant), 64'(3'b010));
        tick();
        req = '0;
        drain();

        // Reset during WAIT, stale response afterwards
        reset_dut();
        q_lat = 5;
        req   = 3'b001;
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_err", 64'(timeout_err), 64'(0));
        chk("t5_count", 64'(blk_count), 64'(0));
        chk("t5_chroma", 64'(q_chroma), 64'(0));
        chk("t5_chan", 64'(out_chan), 64'(0));
        chk_blk("t5_q_z", q_Z, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_valid_stays_low", 64'(out_valid), 64'(0));
        end
        req = 3'b111;
        #1;
        chk("t5_first_grant", 64'(grant), 64'(3'b001));
        tick();
        req = '0;
        drain();

        // Diagonal pattern with negative coefficients on channel 2
        reset_dut();
        q_lat = 3;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (i + j < 7)       b[i][j] = coef_t'(100 + 8 * i + j);
                else if (i + j == 7) b[i][j] = coef_t'(50);
                else                 b[i][j] = coef_t'(((i + j) % 3) - 1);
        blk_in[2] = b;
        req       = 3'b100;
        #1;
        chk("t6_grant", 64'(grant), 64'(3'b100));
        tick();
        req = '0;
        chk("t6_chroma", 64'(q_chroma), 64'(1));
        wait_valid(20);
        chk("t6_chan", 64'(out_chan), 64'(2));
        chk("t6_blk00", 64'($signed(out_blk[0][0])), 64'(50));
        chk("t6_blk07", 64'($signed(out_blk[0][7])), 64'(25));
        chk("t6_blk27", 64'($signed(out_blk[2][7])), 64'(-1));
        chk("t6_blk17", 64'($signed(out_blk[1][7])), 64'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Randomized traffic: random requests, data, latency, backpressure, timeouts and resets
        rnd_q  = 1'b1;
        last_g = '0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            req = req & ~last_g;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!req[c]) begin
                    blk_in[c] = rand_blk();
                    if ($urandom_range(0, 3) == 0) req[c] = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 399) == 0);
            #1;
            last_g = grant;
        end
        tick();
        rst       = 1'b0;
        req       = '0;
        rnd_q     = 1'b0;
        q_mute    = 1'b0;
        out_ready = 1'b1;
        repeat (100) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
